// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the MMIO job sequencer and anything that talks to
// the RV32I core's MMIO host port (firmware builds, benches).
//   seq_state_t : sequencer FSM states
//   OP_*        : operation codes understood by the core firmware
//   job_t       : one buffered job {a, b, op}, 66 bits packed
//   MMIO_*      : host port register addresses as seen by the core
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } job_t;

    localparam int JOB_W = $bits(job_t);

    localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
    localparam logic [31:0] MMIO_A_ADDR   = MMIO_BASE + 32'h0;
    localparam logic [31:0] MMIO_B_ADDR   = MMIO_BASE + 32'h4;
    localparam logic [31:0] MMIO_OP_ADDR  = MMIO_BASE + 32'h8;
    localparam logic [31:0] MMIO_RES_ADDR = MMIO_BASE + 32'hC;

endpackage

// File: rtl/mmio_job_sequencer_if.sv
// mmio_job_sequencer_if
// Bundles the host job/result channels and the core-facing MMIO signals.
//   slave  : view of the sequencer (accepts jobs, drives the core)
//   master : view of the surroundings (host + core)
// Host side : job_valid/job_ready/job_a/job_b/job_op,
//             res_valid/res_ready/res_data/res_x3/res_timeout
// Core side : cpu_rst/cpu_in_a/cpu_in_b/cpu_op,
//             cpu_out_res/cpu_out_valid/cpu_x3/cpu_done
interface mmio_job_sequencer_if;

    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_a;
    logic [31:0] job_b;
    logic [1:0]  job_op;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] res_x3;
    logic        res_timeout;

    logic        cpu_rst;
    logic [31:0] cpu_in_a;
    logic [31:0] cpu_in_b;
    logic [1:0]  cpu_op;
    logic [31:0] cpu_out_res;
    logic        cpu_out_valid;
    logic [31:0] cpu_x3;
    logic        cpu_done;

    modport slave (
        input  job_valid, job_a, job_b, job_op, res_ready,
        input  cpu_out_res, cpu_out_valid, cpu_x3, cpu_done,
        output job_ready, res_valid, res_data, res_x3, res_timeout,
        output cpu_rst, cpu_in_a, cpu_in_b, cpu_op
    );

    modport master (
        output job_valid, job_a, job_b, job_op, res_ready,
        output cpu_out_res, cpu_out_valid, cpu_x3, cpu_done,
        input  job_ready, res_valid, res_data, res_x3, res_timeout,
        input  cpu_rst, cpu_in_a, cpu_in_b, cpu_op
    );

endinterface

// File: rtl/job_fifo.sv
// job_fifo
// Synchronous first-word-fall-through FIFO of job_t entries.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   i_push       : write i_push_data (ignored while full, even if popping)
//   i_pop        : drop the head entry (ignored while empty)
//   o_head       : current head entry, valid whenever !o_empty
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
module job_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  job_t i_push_data,
    input  logic i_pop,
    output job_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    job_t          r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Head is read combinationally so a job pushed at one edge can be popped
    // at the very next edge; the array is only a handful of entries.
    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_job_sequencer.sv
// mmio_job_sequencer
// Feeds buffered (a, b, op) jobs to the RV32I core one at a time: holds the
// core in reset, releases it, waits for done (or a cycle timeout) and hands
// the result word plus x3 back to the host over a valid/ready channel.
//   clk, rst : clock, synchronous active-high reset (flushes everything)
//   bus      : mmio_job_sequencer_if.slave -- host job/result channels and
//              the core's reset, MMIO inputs and result/x3/done outputs
// Parameters: DEPTH job FIFO entries, RST_CYCLES core reset length per job,
//             TIMEOUT maximum RUN cycles before a job is aborted.
module mmio_job_sequencer
    import mmio_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_job_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [RC_W-1:0]   r_rst_cnt;
    logic              r_cpu_rst;
    logic [31:0]       r_cpu_in_a;
    logic [31:0]       r_cpu_in_b;
    logic [1:0]        r_cpu_op;
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic [31:0]       r_res_x3;
    logic              r_res_timeout;

    job_t              w_job_in;
    job_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_job_in = '{a: bus.job_a, b: bus.job_b, op: bus.job_op};

    // Held low while in reset so the host never sees a spurious accept.
    assign bus.job_ready = ~rst & ~w_full;
    assign w_push        = bus.job_valid & bus.job_ready;
    assign w_pop         = (r_state == ST_IDLE) & ~w_empty;

    job_fifo #(
        .DEPTH(DEPTH)
    ) u_job_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_job_in),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rst_cnt     <= '0;
            r_cpu_rst     <= 1'b1;
            r_cpu_in_a    <= '0;
            r_cpu_in_b    <= '0;
            r_cpu_op      <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_x3      <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cpu_rst <= 1'b1;
                    if (!w_empty) begin
                        r_cpu_in_a <= w_head.a;
                        r_cpu_in_b <= w_head.b;
                        r_cpu_op   <= w_head.op;
                        r_cnt      <= '0;
                        r_rst_cnt  <= '0;
                        r_state    <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == RC_LAST) begin
                        r_cpu_rst <= 1'b0;
                        r_state   <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Leaves RUN at TIMEOUT at the latest, which fits CNT_W.
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.cpu_done) begin
                        // done takes priority over a timeout on the same cycle
                        r_res_data    <= bus.cpu_out_valid ? bus.cpu_out_res : '0;
                        r_res_x3      <= bus.cpu_x3;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_cpu_rst     <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_res_data    <= '0;
                        r_res_x3      <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_cpu_rst     <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rst     = r_cpu_rst;
    assign bus.cpu_in_a    = r_cpu_in_a;
    assign bus.cpu_in_b    = r_cpu_in_b;
    assign bus.cpu_op      = r_cpu_op;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_x3      = r_res_x3;
    assign bus.res_timeout = r_res_timeout;

endmodule

// File: tb/tb_mmio_job_sequencer.sv
// tb_mmio_job_sequencer
// Directed bench: one sequencer with a behavioural core model (TIMEOUT=1024)
// and a second one with done tied low (TIMEOUT=16) for the timeout timing.
module tb_mmio_job_sequencer;
    import mmio_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_job_sequencer_if bus ();
    mmio_job_sequencer_if bus_t ();

    mmio_job_sequencer #(.DEPTH(4), .RST_CYCLES(2), .TIMEOUT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mmio_job_sequencer #(.DEPTH(4), .RST_CYCLES(2), .TIMEOUT(16)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_hs    = 0;
    int core_lat = 0;   // RUN cycles until done; 0 = never finishes
    int run_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Core model: counts cycles out of reset, then raises done with a+b or a-b.
    always @(posedge clk) begin
        #1;
        if (bus.cpu_rst) begin
            run_cnt           = 0;
            bus.cpu_done      = 1'b0;
            bus.cpu_out_valid = 1'b0;
            bus.cpu_out_res   = 32'h0;
            bus.cpu_x3        = 32'h0;
        end else begin
            run_cnt++;
            bus.cpu_x3 = 32'h1000 + bus.cpu_in_a;
            if (core_lat != 0 && run_cnt == core_lat) begin
                bus.cpu_done      = 1'b1;
                bus.cpu_out_valid = 1'b1;
                bus.cpu_out_res   = (bus.cpu_op == OP_SUB) ? bus.cpu_in_a - bus.cpu_in_b
                                                           : bus.cpu_in_a + bus.cpu_in_b;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            n_hs++;
            $display("txn result data=%h x3=%h timeout=%0d", bus.res_data, bus.res_x3, bus.res_timeout);
        end
    end

    task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int k;
        bus.job_a = a; bus.job_b = b; bus.job_op = op; bus.job_valid = 1'b1;
        k = 0;
        while (!bus.job_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("push_ready", 32'(bus.job_ready), 32'd1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        $display("txn push a=%h b=%h op=%0d", a, b, op);
    endtask

    task automatic get_result(input string tag, input logic [31:0] e_data, input logic [31:0] e_x3,
                              input logic e_to, output int gap);
        bus.res_ready = 1'b1;
        gap = 0;
        while (!bus.res_valid && gap < 2000) begin
            @(negedge clk);
            gap++;
        end
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_data"}, bus.res_data, e_data);
        chk({tag, "_x3"}, bus.res_x3, e_x3);
        chk({tag, "_to"}, 32'(bus.res_timeout), 32'(e_to));
        @(negedge clk);
        chk({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        int gap, n, acc, lowcnt;
        bus.job_valid = 1'b0; bus.job_a = '0; bus.job_b = '0; bus.job_op = '0; bus.res_ready = 1'b1;
        bus_t.job_valid = 1'b0; bus_t.job_a = '0; bus_t.job_b = '0; bus_t.job_op = '0;
        bus_t.res_ready = 1'b1; bus_t.cpu_done = 1'b0; bus_t.cpu_out_valid = 1'b1;
        bus_t.cpu_out_res = 32'hAAAA_AAAA; bus_t.cpu_x3 = 32'h0000_DEAD;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_job_ready", 32'(bus.job_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rst_cpu_in_a", bus.cpu_in_a, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_job_ready", 32'(bus.job_ready), 32'd1);

        // Timeout instance: RUN entry to res_valid is exactly 16 cycles
        bus_t.job_a = 32'd9; bus_t.job_b = 32'd1; bus_t.job_valid = 1'b1;
        @(negedge clk);
        bus_t.job_valid = 1'b0;
        n = 0;
        while (bus_t.cpu_rst && n < 20) begin @(negedge clk); n++; end
        chk("to_run", 32'(bus_t.cpu_rst), 32'd0);
        n = 0;
        while (!bus_t.res_valid && n < 100) begin @(negedge clk); n++; end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_flag", 32'(bus_t.res_timeout), 32'd1);
        chk("to_data", bus_t.res_data, 32'd0);
        chk("to_x3", bus_t.res_x3, 32'd0);
        @(negedge clk);
        chk("to_drop", 32'(bus_t.res_valid), 32'd0);
        $display("txn timeout-instance result after %0d run cycles", n);

        // Single job 5+7, done after 20 cycles; check pop/reset/run timing
        core_lat = 20;
        push_job(32'd5, 32'd7, OP_ADD);
        @(negedge clk);
        chk("j1_pop_a", bus.cpu_in_a, 32'd5);
        chk("j1_pop_rst", 32'(bus.cpu_rst), 32'd1);
        @(negedge clk);
        chk("j1_reset2", 32'(bus.cpu_rst), 32'd1);
        @(negedge clk);
        chk("j1_run", 32'(bus.cpu_rst), 32'd0);
        get_result("j1", 32'h0000_000C, 32'h0000_1005, 1'b0, gap);
        repeat (30) @(negedge clk);
        chk("j1_once", 32'(n_hs), 32'd1);

        // Three jobs back to back, results in order
        core_lat = 5;
        push_job(32'd10, 32'd3, OP_SUB);
        push_job(32'd1, 32'd2, OP_SUB);
        push_job(32'd0, 32'd0, OP_ADD);
        get_result("j2a", 32'h0000_0007, 32'h0000_100A, 1'b0, gap);
        get_result("j2b", 32'hFFFF_FFFF, 32'h0000_1001, 1'b0, gap);
        chk("j2b_gap", 32'(gap >= 4), 32'd1);
        get_result("j2c", 32'h0000_0000, 32'h0000_1000, 1'b0, gap);
        chk("j2c_gap", 32'(gap >= 4), 32'd1);
        chk("j2_count", 32'(n_hs), 32'd4);

        // Result held while host stalls res_ready
        bus.res_ready = 1'b0;
        push_job(32'd3, 32'd4, OP_ADD);
        push_job(32'd20, 32'd1, OP_SUB);
        n = 0;
        while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_data", bus.res_data, 32'd7);
            chk("hold_cpu_rst", 32'(bus.cpu_rst), 32'd1);
            chk("hold_in_a", bus.cpu_in_a, 32'd3);
            @(negedge clk);
        end
        get_result("h1", 32'd7, 32'h0000_1003, 1'b0, gap);
        get_result("h2", 32'h0000_0013, 32'h0000_1014, 1'b0, gap);
        chk("h_count", 32'(n_hs), 32'd6);

        // Stalled core: 1 in flight + 4 buffered, then job_ready drops
        core_lat = 0;
        bus.res_ready = 1'b0;
        acc = 0;
        bus.job_b = 32'd0; bus.job_op = OP_ADD; bus.job_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.job_a = 32'(100 + acc);
            if (bus.job_ready) acc++;
            @(negedge clk);
        end
        bus.job_valid = 1'b0;
        $display("txn stall pushes accepted=%0d", acc);
        chk("stall_accepted", 32'(acc), 32'd5);
        chk("stall_full", 32'(bus.job_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            get_result("stall", 32'd0, 32'd0, 1'b1, gap);
            chk("stall_order", bus.cpu_in_a, 32'(100 + k));
        end
        chk("stall_count", 32'(n_hs), 32'd11);

        // Reset pulse during RUN with two jobs queued
        bus.res_ready = 1'b1;
        push_job(32'd1, 32'd1, OP_ADD);
        push_job(32'd2, 32'd2, OP_ADD);
        push_job(32'd3, 32'd3, OP_ADD);
        n = 0;
        while (bus.cpu_rst && n < 20) begin @(negedge clk); n++; end
        chk("rr_in_run", 32'(bus.cpu_rst), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rr_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rr_in_a", bus.cpu_in_a, 32'd0);
        chk("rr_ready_in_rst", 32'(bus.job_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rr_job_ready", 32'(bus.job_ready), 32'd1);
        lowcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.cpu_rst) lowcnt++;
            @(negedge clk);
        end
        chk("rr_no_pop", 32'(lowcnt), 32'd0);
        chk("rr_no_result", 32'(n_hs), 32'd11);

        // Normal operation after reset
        core_lat = 5;
        push_job(32'd8, 32'd2, OP_SUB);
        get_result("post", 32'd6, 32'h0000_1008, 1'b0, gap);
        chk("post_count", 32'(n_hs), 32'd12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
